// File: rtl/unary_binary_mac_array_if.sv
// unary_binary_mac_array_if: operand/result handshake bundle for the unary-binary MAC array
interface unary_binary_mac_array_if #(parameter int WIDTH = 4, parameter int LANES = 4, parameter int ACC_W = 10);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_acc;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic [LANES*WIDTH-1:0] in_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] out_acc;
    logic [LANES-1:0]       out_ovf;
    modport master (output in_valid, in_acc, in_a, in_b, in_c, out_ready,
                    input in_ready, out_valid, out_acc, out_ovf);
    modport slave (input in_valid, in_acc, in_a, in_b, in_c, out_ready,
                   output in_ready, out_valid, out_acc, out_ovf);
endinterface

// File: rtl/unary_binary_mac_array.sv
// unary_binary_mac_array: multi-lane MAC where operand a is streamed as a unary pulse train adding b per cycle
module unary_binary_mac_array #(
    parameter int WIDTH = 4,
    parameter int LANES = 4,
    parameter int ACC_W = 10
) (
    input logic clk,
    input logic reset_n,
    unary_binary_mac_array_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, max_a, max_in;
    logic [WIDTH-1:0] a_r [LANES];
    logic [WIDTH-1:0] b_r [LANES];
    logic [ACC_W-1:0] acc [LANES];
    logic [ACC_W:0]   sum [LANES];
    logic [LANES-1:0] ovf;
    logic             accept;
    assign accept = bus.in_valid && bus.in_ready;
    always_comb begin
        max_in = '0;
        for (int l = 0; l < LANES; l++)
            if (bus.in_a[l*WIDTH +: WIDTH] > max_in) max_in = bus.in_a[l*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = (state == IDLE) ? (accept ? ((max_in == '0) ? DONE : RUN) : IDLE) :
                   (state == RUN)  ? ((cnt == max_a - WIDTH'(1)) ? DONE : RUN) :
                   (bus.out_ready ? IDLE : DONE);
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end
    // One shared adder per lane: accept adds c to (acc or 0), RUN adds b
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ACC_W-1:0] base, addend;
        assign base   = (accept && !bus.in_acc) ? '0 : acc[g];
        assign addend = ACC_W'(accept ? bus.in_c[g*WIDTH +: WIDTH] : b_r[g]);
        assign sum[g] = {1'b0, base} + {1'b0, addend};
        assign bus.out_acc[g*ACC_W +: ACC_W] = acc[g];
    end
    assign bus.out_ovf = ovf;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt   <= '0;
            max_a <= '0;
            ovf   <= '0;
            for (int l = 0; l < LANES; l++) begin
                a_r[l] <= '0;
                b_r[l] <= '0;
                acc[l] <= '0;
            end
        end else if (accept) begin
            cnt   <= '0;
            max_a <= max_in;
            for (int l = 0; l < LANES; l++) begin
                a_r[l] <= bus.in_a[l*WIDTH +: WIDTH];
                b_r[l] <= bus.in_b[l*WIDTH +: WIDTH];
                acc[l] <= sum[l][ACC_W-1:0];
                ovf[l] <= (bus.in_acc & ovf[l]) | sum[l][ACC_W];
            end
        end else if (state == RUN) begin
            cnt <= cnt + WIDTH'(1);
            for (int l = 0; l < LANES; l++)
                if (cnt < a_r[l]) begin
                    acc[l] <= sum[l][ACC_W-1:0];
                    ovf[l] <= ovf[l] | sum[l][ACC_W];
                end
        end
endmodule
